spi_flash_reader: RTL and testbench

Hardware read sequencer that sits directly upstream of the byte-level SPI controller. It drives that controller's byte-strobe interface, chip select and mode so the CPU is not involved. On a start request it asserts chip select and issues a standard flash READ command (opcode plus 24-bit address). It then clocks out a requested number of data bytes and delivers them on a valid/ready byte stream to a downstream consumer (FIFO, DMA, or boot loader).

---
 rtl/spi_flash_pkg.sv | 33 +++
 rtl/spi_flash_reader.sv | 153 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_HDR_ISSUE,
    ST_HDR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_OUT_HOLD,
    ST_CS_HOLD
  } sfr_state_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_DUMMY     = 8'h00;
  localparam logic [3:0] SPI_DE_SINGLE = 4'b0001;

  // Header byte k of a READ: opcode, then address MSB first.
  function automatic logic [7:0] hdr_byte(input logic [7:0] cmd,
                                          input logic [23:0] a,
                                          input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = cmd;
      2'd1:    b = a[23:16];
      2'd2:    b = a[15:8];
      default: b = a[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// Read sequencer in front of the byte-level SPI controller: issues a flash
// READ (opcode + 24-bit address) then streams len data bytes out on a
// valid/ready interface with a single-byte buffer.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | chip select high, waiting for start
// ST_CS_SETUP  | chip select low for one cycle before the first strobe
// ST_HDR_ISSUE | strobe header byte hdr_idx (opcode / address bytes)
// ST_HDR_WAIT  | blank cycle, then wait for controller idle
// ST_RD_ISSUE  | strobe a dummy byte to clock in one data byte
// ST_RD_WAIT   | blank cycle, then wait for idle and capture the rx byte
// ST_OUT_HOLD  | data byte presented, held until the consumer takes it
// ST_CS_HOLD   | one cycle of chip select low after the last byte
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [2:0] MODE = 3'd0,
  parameter logic [7:0] CMD  = SPI_CMD_READ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        spi_cs,
  output logic [2:0]  spi_mode,
  output logic [3:0]  spi_data_enable,
  output logic [7:0]  spi_byte_tx,
  output logic        spi_byte_tx_strobe,
  input  logic [7:0]  spi_byte_rx,
  input  logic        spi_idle
);

  sfr_state_t  state_q, state_d;
  logic [23:0] addr_q;
  logic [15:0] rem_q;
  logic [1:0]  hdr_idx_q;
  logic        blank_q;
  logic        done_q;
  logic [7:0]  data_q;

  logic        latch;
  logic        hdr_next;
  logic        capture;
  logic        handshake;
  logic        zero_len;

  assign zero_len = (len == 16'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode plus the datapath enables it implies.
  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    hdr_next  = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !zero_len) begin
          latch   = 1'b1;
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP:  state_d = ST_HDR_ISSUE;
      ST_HDR_ISSUE: state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: begin
        if (!blank_q && spi_idle) begin
          if (hdr_idx_q == 2'd3) begin
            state_d = ST_RD_ISSUE;
          end else begin
            hdr_next = 1'b1;
            state_d  = ST_HDR_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!blank_q && spi_idle) begin
          capture = 1'b1;
          state_d = ST_OUT_HOLD;
        end
      end
      ST_OUT_HOLD: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_d   = (rem_q == 16'd1) ? ST_CS_HOLD : ST_RD_ISSUE;
        end
      end
      ST_CS_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request latch, header index and remaining-byte down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      rem_q     <= '0;
      hdr_idx_q <= '0;
    end else begin
      if (latch) begin
        addr_q    <= addr;
        rem_q     <= len;
        hdr_idx_q <= '0;
      end
      if (hdr_next)  hdr_idx_q <= hdr_idx_q + 2'd1;
      if (handshake) rem_q     <= rem_q - 16'd1;
    end
  end

  // The controller's idle flag lags a strobe by a cycle, so the first wait
  // cycle after any strobe is masked.
  always_ff @(posedge clk) begin
    if (reset) blank_q <= 1'b0;
    else       blank_q <= spi_byte_tx_strobe;
  end

  // Output byte buffer and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (capture) data_q <= spi_byte_rx;
      done_q <= (state_q == ST_CS_HOLD) ||
                ((state_q == ST_IDLE) && start && zero_len);
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign out_valid          = (state_q == ST_OUT_HOLD);
  assign out_data           = data_q;
  assign spi_cs             = (state_q == ST_IDLE);
  assign spi_mode           = MODE;
  assign spi_data_enable    = spi_cs ? 4'b0000 : SPI_DE_SINGLE;
  assign spi_byte_tx_strobe = (state_q == ST_HDR_ISSUE) || (state_q == ST_RD_ISSUE);
  assign spi_byte_tx        = (state_q == ST_HDR_ISSUE) ? hdr_byte(CMD, addr_q, hdr_idx_q)
                                                        : SPI_DUMMY;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural byte controller
// and flash model.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        spi_cs;
  logic [2:0]  spi_mode;
  logic [3:0]  spi_data_enable;
  logic [7:0]  spi_byte_tx;
  logic        spi_byte_tx_strobe;
  logic [7:0]  spi_byte_rx = 8'h00;
  logic        spi_idle = 1'b1;

  spi_flash_reader dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .spi_cs(spi_cs), .spi_mode(spi_mode),
    .spi_data_enable(spi_data_enable), .spi_byte_tx(spi_byte_tx),
    .spi_byte_tx_strobe(spi_byte_tx_strobe), .spi_byte_rx(spi_byte_rx),
    .spi_idle(spi_idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, hs_cyc = 0, cs_rise_cyc = 0, strobe_cnt = 0;
  logic [7:0] tx_log[$];
  logic [7:0] out_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash contents: two fixed bytes, otherwise low address byte xor 3C.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h123456) return 8'hA5;
    if (a == 24'h123457) return 8'h5A;
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Controller/flash model and protocol monitor, all sampled mid-cycle.
  int         busy_cyc = 0;
  int         fl_idx = 0;
  logic [23:0] fl_addr = '0;
  logic [7:0] pend_rx = '0;
  logic       prev_strobe = 1'b0;
  logic       prev_cs = 1'b1;
  always @(negedge clk) begin
    if (cyc > 2) begin
      check("strobe_b2b", 32'(spi_byte_tx_strobe & prev_strobe), 32'd0);
      check("strobe_cs_high", 32'(spi_byte_tx_strobe & spi_cs), 32'd0);
      check("data_enable", 32'(spi_data_enable), spi_cs ? 32'd0 : 32'd1);
    end
    if (spi_cs) fl_idx = 0;
    if (busy_cyc != 0) begin
      busy_cyc--;
      if (busy_cyc == 0) begin
        spi_idle    = 1'b1;
        spi_byte_rx = pend_rx;
      end
    end
    if (spi_byte_tx_strobe) begin
      strobe_cnt++;
      tx_log.push_back(spi_byte_tx);
      case (fl_idx)
        0: pend_rx = 8'hEE;
        1: begin fl_addr[23:16] = spi_byte_tx; pend_rx = 8'hEE; end
        2: begin fl_addr[15:8]  = spi_byte_tx; pend_rx = 8'hEE; end
        3: begin fl_addr[7:0]   = spi_byte_tx; pend_rx = 8'hEE; end
        default: pend_rx = flash_byte(fl_addr + 24'(fl_idx - 4));
      endcase
      fl_idx++;
      busy_cyc = 3;
      spi_idle = 1'b0;
    end
    if (out_valid && out_ready) begin
      out_log.push_back(out_data);
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (spi_cs && !prev_cs) cs_rise_cyc = cyc;
    prev_strobe = spi_byte_tx_strobe;
    prev_cs     = spi_cs;
  end

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; addr = a; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk); #1;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    out_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int s0;
    logic [7:0] exp_tx1[6] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
    logic [7:0] exp_out3[4] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F};
    logic [7:0] exp_tx5[5] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_strobe", 32'(spi_byte_tx_strobe), 32'd0);
    check("rst_tx", 32'(spi_byte_tx), 32'd0);
    check("rst_de", 32'(spi_data_enable), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mode", 32'(spi_mode), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic two-byte read.
    clear_logs();
    out_ready = 1'b1;
    do_start(24'h123456, 16'd2);
    check("t1_cs_low", 32'(spi_cs), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_setup_nostrobe", 32'(spi_byte_tx_strobe), 32'd0);
    @(posedge clk); #1;
    check("t1_first_strobe", 32'(spi_byte_tx_strobe), 32'd1);
    check("t1_cmd", 32'(spi_byte_tx), 32'h03);
    wait_done(300, ok);
    check("t1_done_seen", 32'(ok), 32'd1);
    check("t1_cs_at_done", 32'(spi_cs), 32'd1);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("t1_tx_count", 32'(tx_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t1_tx%0d", i), 32'(tx_log[i]), 32'(exp_tx1[i]));
    check("t1_out_count", 32'(out_log.size()), 32'd2);
    check("t1_out0", 32'(out_log[0]), 32'hA5);
    check("t1_out1", 32'(out_log[1]), 32'h5A);
    check("t1_hs_to_done", 32'(done_cyc - hs_cyc), 32'd2);
    check("t1_cs_rise_at_done", 32'(cs_rise_cyc), 32'(done_cyc));
    repeat (5) @(posedge clk);
    #1;
    check("t1_done_count", 32'(done_cnt), 32'd1);

    // Zero-length request.
    clear_logs();
    s0 = strobe_cnt;
    do_start(24'h000050, 16'd0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_cs", 32'(spi_cs), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t2_done_pulse", 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t2_no_strobe", 32'(strobe_cnt), 32'(s0));
    check("t2_cs_still_high", 32'(spi_cs), 32'd1);

    // Backpressure on the first byte.
    clear_logs();
    out_ready = 1'b0;
    do_start(24'h000100, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if (out_valid) ok = 1'b1;
    end
    check("t3_valid_seen", 32'(ok), 32'd1);
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("t3_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t3_hold_data%0d", i), 32'(out_data), 32'h3C);
    end
    check("t3_no_strobe_stall", 32'(strobe_cnt), 32'(s0));
    out_ready = 1'b1;
    wait_done(400, ok);
    check("t3_done_seen", 32'(ok), 32'd1);
    @(negedge clk); #1;
    check("t3_out_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_out%0d", i), 32'(out_log[i]), 32'(exp_out3[i]));
    check("t3_tx_count", 32'(tx_log.size()), 32'd8);

    // Second start while busy is ignored.
    clear_logs();
    do_start(24'h000200, 16'd3);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1; addr = 24'h000300; len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400, ok);
    check("t4_done_seen", 32'(ok), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("t4_out_count", 32'(out_log.size()), 32'd3);
    check("t4_out0", 32'(out_log[0]), 32'h3C);
    check("t4_out2", 32'(out_log[2]), 32'h3E);
    check("t4_tx_count", 32'(tx_log.size()), 32'd7);
    check("t4_done_count", 32'(done_cnt), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);

    // Reset during the second address byte, then a fresh one-byte read.
    clear_logs();
    do_start(24'hABCDEF, 16'd2);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (spi_byte_tx_strobe && spi_byte_tx == 8'hCD) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t5_addr_mid_seen", 32'(ok), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_cs", 32'(spi_cs), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_strobe", 32'(spi_byte_tx_strobe), 32'd0);
    s0 = strobe_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("t5_no_strobe_after_rst", 32'(strobe_cnt), 32'(s0));

    clear_logs();
    do_start(24'h000000, 16'd1);
    check("t6_setup_gap", 32'(spi_byte_tx_strobe), 32'd0);
    @(posedge clk); #1;
    check("t6_strobe_after_setup", 32'(spi_byte_tx_strobe), 32'd1);
    wait_done(300, ok);
    check("t6_done_seen", 32'(ok), 32'd1);
    @(negedge clk); #1;
    check("t6_tx_count", 32'(tx_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t6_tx%0d", i), 32'(tx_log[i]), 32'(exp_tx5[i]));
    check("t6_out_count", 32'(out_log.size()), 32'd1);
    check("t6_out0", 32'(out_log[0]), 32'h3C);
    check("t6_hold_gap", 32'(done_cyc - hs_cyc), 32'd2);
    check("t6_done_count", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
